// File: rtl/host_mem_pkg.sv
// ---------------------------------------------------------------------------
// host_mem_pkg
// Shared definitions for the multi-port host memory model:
//   ERR_RDATA      - read data returned with an out-of-range response
//   MAX_PORTS      - upper bound on the number of OBI slave ports
//   MAX_RD_LATENCY - upper bound on the response pipeline depth
//   rsp_entry_t    - one slot of the response pipeline
//   be_merge()     - byte-enable merge of a write into an existing word
// ---------------------------------------------------------------------------
package host_mem_pkg;

    localparam logic [31:0] ERR_RDATA      = 32'hBAD0_ADD4;
    localparam int          MAX_PORTS      = 8;
    localparam int          MAX_RD_LATENCY = 8;

    // Port index is 3 bits wide so that up to MAX_PORTS ports fit.
    typedef struct packed {
        logic        valid;
        logic [2:0]  port;
        logic [31:0] rdata;
        logic        err;
    } rsp_entry_t;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/host_mem_mp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter over N requesters. The first requester at or after the
// pointer (wrapping modulo N) wins; after a grant to k the pointer moves to
// (k+1) mod N, otherwise it holds.
//   clk, rst : clock and synchronous active-high reset (pointer -> 0)
//   req      : request vector (already masked by the caller)
//   gnt      : one-hot grant, combinational from req and the pointer
//   gnt_idx  : index of the granted requester (0 when nothing is granted)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;
    int               cand_int_s;

    // Search the requesters starting at the pointer and take the first one.
    always_comb begin
        gnt        = '0;
        gnt_idx    = '0;
        found_s    = 1'b0;
        cand_int_s = 0;
        cand_s     = '0;
        for (int i = 0; i < N; i++) begin
            cand_int_s = int'(ptr_r) + i;
            if (cand_int_s >= N) begin
                cand_int_s = cand_int_s - N;
            end else begin
                cand_int_s = cand_int_s;
            end
            cand_s = IDX_W'(cand_int_s);
            if (!found_s && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                gnt_idx     = cand_s;
                found_s     = 1'b1;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Pointer moves just past the granted requester; it holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IDX_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/host_mem_mp.sv
// ---------------------------------------------------------------------------
// host_mem_mp
// Multi-port host memory model. NUM_PORTS OBI slave ports share one
// word-addressed array through a round-robin arbiter (one grant per cycle).
// Every granted access produces exactly one response RD_LATENCY cycles after
// the grant edge; out-of-range accesses return ERR_RDATA with err set.
//   clk_i, rst_i : clock, synchronous active-high reset (array not cleared)
//   req_i/gnt_o  : per-port request / combinational grant
//   addr_i       : per-port byte address (bits [1:0] ignored)
//   we_i, be_i, wdata_i : per-port write enable, byte enables, write data
//   rvalid_o, rdata_o, err_o : per-port single-cycle response
//   stall_i      : per-port grant mask for back-pressure injection
//   acc_cnt_o    : saturating count of granted transactions
// The array is named mem_array so benches can preload / dump it directly.
// ---------------------------------------------------------------------------
module host_mem_mp
    import host_mem_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int MEM_SIZE_WORD = 32768,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int RD_LATENCY    = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_PORTS-1:0]             req_i,
    output logic [NUM_PORTS-1:0]             gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS-1:0]             we_i,
    input  logic [NUM_PORTS*4-1:0]           be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_PORTS-1:0]             rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  rdata_o,
    output logic [NUM_PORTS-1:0]             err_o,
    input  logic [NUM_PORTS-1:0]             stall_i,
    output logic [31:0]                      acc_cnt_o
);

    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int MEM_AW = (MEM_SIZE_WORD > 1) ? $clog2(MEM_SIZE_WORD) : 1;
    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] MEM_SIZE_L = WORD_W'(MEM_SIZE_WORD);

    logic [31:0] mem_array [0:MEM_SIZE_WORD-1];

    logic [NUM_PORTS-1:0] elig_s;
    logic [NUM_PORTS-1:0] gnt_s;
    logic [IDX_W-1:0]     gnt_idx_s;
    logic                 gnt_any_s;

    logic [WORD_W-1:0]    sel_word_s;
    logic                 sel_we_s;
    logic [3:0]           sel_be_s;
    logic [31:0]          sel_wdata_s;
    logic                 unused_addr_lsb_s;

    logic                 in_range_s;
    logic [MEM_AW-1:0]    mem_idx_s;
    logic                 wr_en_s;

    rsp_entry_t           new_entry_s;
    rsp_entry_t           pipe_r [0:RD_LATENCY-1];
    rsp_entry_t           out_entry_s;

    logic [31:0]          acc_cnt_r;

    assign elig_s    = req_i & ~stall_i;
    assign gnt_any_s = |gnt_s;
    assign gnt_o     = gnt_s;
    assign acc_cnt_o = acc_cnt_r;

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     (elig_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Route the granted port's command fields onto the shared array path.
    always_comb begin
        sel_word_s  = '0;
        sel_we_s    = 1'b0;
        sel_be_s    = 4'h0;
        sel_wdata_s = 32'h0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt_s[k]) begin
                sel_word_s  = addr_i[k*ADDR_WIDTH+2 +: WORD_W];
                sel_we_s    = we_i[k];
                sel_be_s    = be_i[k*4 +: 4];
                sel_wdata_s = wdata_i[k*DATA_WIDTH +: 32];
            end else begin
                sel_word_s  = sel_word_s;
            end
        end
    end

    // Byte offset bits carry no meaning for a word-addressed array.
    always_comb begin
        unused_addr_lsb_s = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            unused_addr_lsb_s = unused_addr_lsb_s ^ (^addr_i[k*ADDR_WIDTH +: 2]);
        end
    end

    assign in_range_s = (sel_word_s < MEM_SIZE_L);
    assign mem_idx_s  = sel_word_s[MEM_AW-1:0];
    assign wr_en_s    = gnt_any_s & sel_we_s & in_range_s & ~rst_i;

    // Build the response for this cycle's grant; the read sees the array
    // before any write of the same edge, and only one access is granted.
    always_comb begin
        new_entry_s       = '0;
        new_entry_s.valid = gnt_any_s;
        new_entry_s.port  = 3'(gnt_idx_s);
        new_entry_s.err   = gnt_any_s & ~in_range_s;
        if (!gnt_any_s) begin
            new_entry_s.rdata = 32'h0;
        end else if (!in_range_s) begin
            new_entry_s.rdata = ERR_RDATA;
        end else if (sel_we_s) begin
            new_entry_s.rdata = 32'h0;
        end else begin
            new_entry_s.rdata = mem_array[mem_idx_s];
        end
    end

    // Byte-enable write into the array; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_array[mem_idx_s] <= be_merge(mem_array[mem_idx_s], sel_wdata_s, sel_be_s);
        end
    end

    // Fixed-latency response shift pipeline, flushed on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= new_entry_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign out_entry_s = pipe_r[RD_LATENCY-1];

    // Steer the pipeline head to its port; idle ports see all-zero outputs.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        err_o    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (out_entry_s.valid && (out_entry_s.port == 3'(k))) begin
                rvalid_o[k]                     = 1'b1;
                rdata_o[k*DATA_WIDTH +: 32]     = out_entry_s.rdata;
                err_o[k]                        = out_entry_s.err;
            end else begin
                rvalid_o[k]                     = 1'b0;
                rdata_o[k*DATA_WIDTH +: 32]     = 32'h0;
                err_o[k]                        = 1'b0;
            end
        end
    end

    // Saturating count of granted transactions.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_cnt_r <= 32'h0;
        end else if (gnt_any_s && (acc_cnt_r != 32'hFFFF_FFFF)) begin
            acc_cnt_r <= acc_cnt_r + 32'd1;
        end else begin
            acc_cnt_r <= acc_cnt_r;
        end
    end

endmodule

// File: tb/tb_host_mem_mp.sv
// ---------------------------------------------------------------------------
// tb_host_mem_mp
// Scoreboard bench for host_mem_mp with 3 ports and a 4-cycle response
// latency. A negedge monitor models the round-robin arbiter, the array and
// the access counter; each modelled grant pushes the expected response onto
// that port's queue, and responses are popped and compared as they arrive.
// ---------------------------------------------------------------------------
module tb_host_mem_mp;

    localparam int NP   = 3;
    localparam int LAT  = 4;
    localparam int MEMW = 1024;
    localparam int AW   = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NP-1:0]     req_i;
    logic [NP-1:0]     gnt_o;
    logic [NP*AW-1:0]  addr_i;
    logic [NP-1:0]     we_i;
    logic [NP*4-1:0]   be_i;
    logic [NP*32-1:0]  wdata_i;
    logic [NP-1:0]     rvalid_o;
    logic [NP*32-1:0]  rdata_o;
    logic [NP-1:0]     err_o;
    logic [NP-1:0]     stall_i;
    logic [31:0]       acc_cnt_o;

    host_mem_mp #(
        .NUM_PORTS     (NP),
        .MEM_SIZE_WORD (MEMW),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (32),
        .RD_LATENCY    (LAT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .be_i      (be_i),
        .wdata_i   (wdata_i),
        .rvalid_o  (rvalid_o),
        .rdata_o   (rdata_o),
        .err_o     (err_o),
        .stall_i   (stall_i),
        .acc_cnt_o (acc_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          mon_en  = 1'b0;
    logic [31:0] model_mem [0:MEMW-1];
    int          exp_ptr = 0;
    logic [31:0] exp_cnt = 32'h0;
    exp_t        sb_q [NP][$];
    int          gnt_log [$];
    logic [31:0] last_rdata [NP];
    logic        last_err [NP];

    // Monitor scratch
    logic [NP-1:0] m_elig;
    logic [NP-1:0] m_exp_g;
    bit            m_found;
    int            m_gi;
    int            m_idx;
    logic [31:0]   m_addr;
    int            m_word;
    exp_t          m_e;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference model: arbitration, array, counter, response scoreboard.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (rst_i) begin
                exp_ptr = 0;
                exp_cnt = 32'h0;
                for (int p = 0; p < NP; p++) sb_q[p].delete();
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (rvalid_o[p]) begin
                        if (sb_q[p].size() == 0) begin
                            check_val("rsp_unexpected_qsize", 64'(sb_q[p].size()), 64'd1);
                        end else begin
                            m_e = sb_q[p].pop_front();
                            check_val("rsp_rdata", 64'(rdata_o[p*32 +: 32]), 64'(m_e.data));
                            check_val("rsp_err", 64'(err_o[p]), 64'(m_e.err));
                            check_val("rsp_latency_cycle", 64'(cyc), 64'(m_e.due));
                            last_rdata[p] = rdata_o[p*32 +: 32];
                            last_err[p]   = err_o[p];
                        end
                    end else begin
                        check_val("idle_zero", 64'({rdata_o[p*32 +: 32], err_o[p]}), 64'd0);
                    end
                end
                check_val("acc_cnt", 64'(acc_cnt_o), 64'(exp_cnt));

                m_elig  = req_i & ~stall_i;
                m_exp_g = '0;
                m_found = 1'b0;
                m_gi    = 0;
                for (int i = 0; i < NP; i++) begin
                    m_idx = (exp_ptr + i) % NP;
                    if (!m_found && m_elig[m_idx]) begin
                        m_found        = 1'b1;
                        m_gi           = m_idx;
                        m_exp_g[m_idx] = 1'b1;
                    end
                end
                check_val("gnt", 64'(gnt_o), 64'(m_exp_g));

                if (m_found) begin
                    m_addr = addr_i[m_gi*AW +: AW];
                    m_word = int'(m_addr >> 2);
                    m_e.due = cyc + LAT;
                    if (m_word >= MEMW) begin
                        m_e.data = 32'hBAD0_ADD4;
                        m_e.err  = 1'b1;
                    end else if (we_i[m_gi]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be_i[m_gi*4 + b]) model_mem[m_word][8*b +: 8] = wdata_i[m_gi*32 + 8*b +: 8];
                        end
                        m_e.data = 32'h0;
                        m_e.err  = 1'b0;
                    end else begin
                        m_e.data = model_mem[m_word];
                        m_e.err  = 1'b0;
                    end
                    sb_q[m_gi].push_back(m_e);
                    gnt_log.push_back(m_gi);
                    exp_ptr = (m_gi + 1) % NP;
                    if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        req_i   = '0;
        we_i    = '0;
        be_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
    endtask

    function automatic int pending();
        int s = 0;
        for (int p = 0; p < NP; p++) s += sb_q[p].size();
        return s;
    endfunction

    // Hold one request until granted (bounded), then release it.
    task automatic issue(input int p, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        bit done = 1'b0;
        req_i[p]             = 1'b1;
        we_i[p]              = we;
        addr_i[p*AW +: AW]   = addr;
        be_i[p*4 +: 4]       = be;
        wdata_i[p*32 +: 32]  = wd;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk_i);
            done = gnt_o[p];
            @(posedge clk_i);
            #1;
        end
        req_i[p] = 1'b0;
        we_i[p]  = 1'b0;
        check_val("issue_granted", 64'(done), 64'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (pending() != 0 && t < 40) begin
            tick();
            t++;
        end
        check_val("drain_pending", 64'(pending()), 64'd0);
        tick();
    endtask

    task automatic mem_compare(input string tag);
        int mism = 0;
        for (int i = 0; i < MEMW; i++) begin
            if (dut.mem_array[i] !== model_mem[i]) mism++;
        end
        check_val(tag, 64'(mism), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          n0;
        int          n1;
        bit          got1;

        idle_all();
        stall_i = '0;
        for (int i = 0; i < NP; i++) begin
            last_rdata[i] = 32'h0;
            last_err[i]   = 1'b0;
        end
        for (int i = 0; i < MEMW; i++) begin
            w = (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
            dut.mem_array[i] = w;
            model_mem[i]     = w;
        end

        // Reset state
        tick();
        tick();
        rst_i = 1'b0;
        check_val("rst_rvalid", 64'(rvalid_o), 64'd0);
        check_val("rst_err", 64'(err_o), 64'd0);
        check_val("rst_rdata_lo", rdata_o[63:0], 64'd0);
        check_val("rst_acc_cnt", 64'(acc_cnt_o), 64'd0);
        mon_en = 1'b1;

        // Write then read
        issue(0, 1'b1, 32'h100, 4'hF, 32'hCAFE_BABE);
        issue(0, 1'b0, 32'h100, 4'h0, 32'h0);
        drain();
        check_val("wr_rd_data", 64'(last_rdata[0]), 64'h0000_0000_CAFE_BABE);
        check_val("wr_rd_err", 64'(last_err[0]), 64'd0);

        // Byte enables
        dut.mem_array[128] = 32'h1122_3344;
        model_mem[128]     = 32'h1122_3344;
        issue(0, 1'b1, 32'h200, 4'b0101, 32'hAABB_CCDD);
        issue(0, 1'b0, 32'h202, 4'h0, 32'h0);
        drain();
        check_val("be_merge", 64'(last_rdata[0]), 64'h0000_0000_11BB_33DD);

        // Round robin from a fresh pointer
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        gnt_log.delete();
        for (int p = 0; p < NP; p++) addr_i[p*AW +: AW] = 32'(p * 4);
        req_i = 3'b111;
        for (int i = 0; i < 6; i++) tick();
        idle_all();
        check_val("rr_acc_cnt", 64'(acc_cnt_o), 64'd6);
        check_val("rr_count", 64'(gnt_log.size()), 64'd6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) begin
            check_val("rr_seq", 64'(gnt_log[i]), 64'(i % 3));
        end
        drain();

        // Stall on port 1
        gnt_log.delete();
        stall_i = 3'b010;
        addr_i[0 +: AW]  = 32'h40;
        addr_i[AW +: AW] = 32'h44;
        req_i = 3'b011;
        for (int i = 0; i < 10; i++) tick();
        n0 = 0;
        n1 = 0;
        foreach (gnt_log[i]) begin
            if (gnt_log[i] == 0) n0++;
            if (gnt_log[i] == 1) n1++;
        end
        check_val("stall_p1_grants", 64'(n1), 64'd0);
        check_val("stall_p0_grants", 64'(n0), 64'd10);
        stall_i = 3'b000;
        got1 = 1'b0;
        for (int t = 0; t < 2 && !got1; t++) begin
            @(negedge clk_i);
            got1 = gnt_o[1];
            tick();
        end
        idle_all();
        check_val("stall_release_p1", 64'(got1), 64'd1);
        drain();

        // Out of range read and write
        issue(1, 1'b0, 32'(MEMW * 4), 4'h0, 32'h0);
        drain();
        check_val("oor_rd_data", 64'(last_rdata[1]), 64'h0000_0000_BAD0_ADD4);
        check_val("oor_rd_err", 64'(last_err[1]), 64'd1);
        issue(2, 1'b1, 32'(MEMW * 4), 4'hF, 32'hDEAD_BEEF);
        drain();
        check_val("oor_wr_err", 64'(last_err[2]), 64'd1);
        mem_compare("oor_mem_cmp");

        // Mixed random traffic on all ports
        for (int c = 0; c < 40; c++) begin
            for (int p = 0; p < NP; p++) begin
                req_i[p]            = 1'($urandom_range(0, 1));
                we_i[p]             = 1'($urandom_range(0, 1));
                addr_i[p*AW +: AW]  = ($urandom_range(0, 9) == 0) ?
                                      32'(MEMW * 4 + 4 * $urandom_range(0, 3)) :
                                      32'(4 * $urandom_range(0, 31));
                be_i[p*4 +: 4]      = 4'($urandom_range(0, 15));
                wdata_i[p*32 +: 32] = $urandom;
                stall_i[p]          = ($urandom_range(0, 4) == 0);
            end
            tick();
        end
        idle_all();
        stall_i = '0;
        drain();
        mem_compare("rand_mem_cmp");

        // Reset with two reads in flight
        req_i[0]        = 1'b1;
        we_i[0]         = 1'b0;
        addr_i[0 +: AW] = 32'h100;
        tick();
        addr_i[0 +: AW] = 32'h104;
        tick();
        idle_all();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_val("midrst_acc_cnt", 64'(acc_cnt_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check_val("midrst_no_rvalid", 64'(rvalid_o), 64'd0);
            tick();
        end
        mem_compare("midrst_mem_cmp");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/host_mem_mp.md
Name: host_mem_mp

Overview:
Multi-port, parametrised successor of the single-port host memory model that backs e_gpu's host_mem OBI port in simulation. It gives NUM_PORTS OBI slave ports (GPU host port, bench DMA, debug) round-robin access to one word-addressed array. It adds a configurable fixed read latency, per-port grant back-pressure injection, byte-enable writes, out-of-range error responses and an access counter. The bench preloads mem_array hierarchically and dumps it at end of kernel.

Parameters:
NUM_PORTS, 2, number of OBI slave ports (1..8)
MEM_SIZE_WORD, 32768, array depth in 32-bit words
ADDR_WIDTH, 32, OBI address width (byte address)
DATA_WIDTH, 32, OBI data width; only 32 is supported
RD_LATENCY, 1, cycles from grant edge to rvalid (1..8)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  NUM_PORTS  OBI request, per port
gnt_o  out  NUM_PORTS  OBI grant, combinational from req_i/stall_i/rr pointer
addr_i  in  NUM_PORTS*ADDR_WIDTH  byte address per port
we_i  in  NUM_PORTS  write enable per port
be_i  in  NUM_PORTS*4  byte enables per port
wdata_i  in  NUM_PORTS*32  write data per port
rvalid_o  out  NUM_PORTS  response valid per port
rdata_o  out  NUM_PORTS*32  read data per port
err_o  out  NUM_PORTS  response error, qualified by rvalid_o
stall_i  in  NUM_PORTS  bench back-pressure; masks gnt_o for that port
acc_cnt_o  out  32  granted transactions since reset, saturating

Behaviour:
- Reset (rst_i high at posedge): rvalid_o=0, rdata_o=0, err_o=0, acc_cnt_o=0, rr pointer=0, response pipeline flushed. Transactions in flight are dropped. mem_array is NOT cleared.
- Eligible port k: req_i[k] & ~stall_i[k]. Exactly one eligible port is granted per cycle: the first eligible port at or after the rr pointer, wrapping modulo NUM_PORTS. gnt_o asserts in the same cycle as req_i. No grant when none are eligible.
- Pointer update at posedge after a grant to port k: pointer=(k+1) mod NUM_PORTS. With no grant the pointer holds.
- Word index = addr[ADDR_WIDTH-1:2]; addr[1:0] are ignored. In range means index < MEM_SIZE_WORD.
- Granted write, in range: bytes with be=1 are updated at the grant posedge; other bytes are kept. Response has rdata=0, err=0.
- Granted read, in range: the word is sampled at the grant posedge; a write granted in the same edge cannot collide because there is a single grant per cycle. Response has rdata=word, err=0.
- Out of range (read or write): memory is untouched. Response has rdata=32'hBAD0_ADD4, err=1.
- Response latency: rvalid_o[k] pulses for exactly 1 cycle, RD_LATENCY cycles after the grant edge (RD_LATENCY=1 means the cycle after gnt). It is carried in a RD_LATENCY-deep shift pipeline of {valid, port, rdata, err}, and this applies to writes as well.
- Per-port responses arrive in grant order. Back-to-back grants give back-to-back rvalid; responses are never merged.
- When rvalid_o[k]=0, rdata_o[k]=0 and err_o[k]=0.
- acc_cnt_o increments by 1 per grant and stays at 32'hFFFF_FFFF once saturated.
- A request held with stall_i high is never granted. It is granted the first cycle stall_i drops, subject to arbitration.
- NUM_PORTS=1: the arbiter degenerates to gnt=req&~stall.

Decomposition:
- Package host_mem_pkg: ERR_RDATA constant (32'hBAD0_ADD4), MAX_PORTS=8, MAX_RD_LATENCY=8, and the pipeline entry struct rsp_entry_t {valid, port index [2:0], rdata [31:0], err}.
- Sub-module rr_arbiter #(N): inputs req vector and clk/rst; outputs one-hot gnt and the granted index. It owns the rr pointer register.
- The top module holds the array, the byte-enable write, the response pipeline, the per-port response demux and the counter.

Test Plan:
- Write then read: port0 writes 32'hCAFEBABE to 0x100 with be=4'hF, then reads 0x100 -> rvalid on port0 exactly RD_LATENCY cycles after each gnt; rdata=32'hCAFEBABE, err=0.
- Byte enables: preload 0x200=32'h11223344, write 32'hAABBCCDD with be=4'b0101 -> read returns 32'h11BB33DD.
- Round-robin: NUM_PORTS=3, all req held continuously -> gnt sequence 0,1,2,0,1,2; acc_cnt_o=6 after 6 cycles.
- Stall: stall_i[1]=1 for 10 cycles with ports 0 and 1 requesting -> only port0 is granted. Port1 is granted in the first cycle stall drops, or the next cycle if the pointer favours port0.
- Out of range: read at byte address MEM_SIZE_WORD*4 -> err=1, rdata=32'hBAD0_ADD4. A write to the same address leaves the array unchanged (verified via hierarchical compare).
- Reset mid-flight: RD_LATENCY=4, issue 2 reads, assert rst_i for 1 cycle 2 cycles later -> no rvalid follows, acc_cnt_o=0, and array contents are preserved.
